// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared bidirectional data bus.
// Reads have one clock of latency through a read register; the bus is only driven when reading.
module single_port_sync_ram #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdData;

   logic             w_inRange;
   logic             w_doWrite;
   logic             w_doRead;
   logic             w_drive;
   logic [IDX_W-1:0] w_idx;

   // Addresses at or beyond DEPTH never touch storage and read back as zero.
   assign w_inRange = ({1'b0, addr} < DEPTH_V);
   assign w_idx     = addr[IDX_W-1:0];
   assign w_doWrite = cs & we;
   assign w_doRead  = cs & ~we;
   assign w_drive   = cs & oe & ~we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_doWrite && w_inRange) begin
         r_mem[w_idx] <= data;
      end
   end

   // The read register captures on every selected non-write edge, whether or not oe is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdData <= '0;
      end else if (w_doRead) begin
         r_rdData <= w_inRange ? r_mem[w_idx] : '0;
      end
   end

   assign data = w_drive ? r_rdData : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Directed, table-driven bench for single_port_sync_ram: a vector table plus hand-written
// sequences for the asynchronous reset corner cases.
module tb_single_port_sync_ram;

   typedef struct {
      string       name;
      logic        cs;
      logic        we;
      logic        oe;
      logic [3:0]  addr;
      logic        tbDrive;
      logic [31:0] tbData;
      logic [31:0] expBus;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        we;
   logic        oe;
   logic [3:0]  addr;
   logic        tbDrive;
   logic [31:0] tbData;
   wire  [31:0] data;

   int assertCount;
   int failCount;

   vec_t vecs [17];

   assign data = tbDrive ? tbData : 32'hzzzz_zzzz;

   single_port_sync_ram #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(32),
      .DEPTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .addr(addr),
      .data(data),
      .cs  (cs),
      .we  (we),
      .oe  (oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input vec_t v);
      cs      = v.cs;
      we      = v.we;
      oe      = v.oe;
      addr    = v.addr;
      tbDrive = v.tbDrive;
      tbData  = v.tbData;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp);
      assertCount++;
      if (data !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: bus=0x%08h expected=0x%08h", name, data, exp);
      end
   endtask

   task automatic setVec(input int idx, input string name, input logic c, input logic w,
                         input logic o, input logic [3:0] a, input logic drv,
                         input logic [31:0] d, input logic [31:0] e);
      vecs[idx].name    = name;
      vecs[idx].cs      = c;
      vecs[idx].we      = w;
      vecs[idx].oe      = o;
      vecs[idx].addr    = a;
      vecs[idx].tbDrive = drv;
      vecs[idx].tbData  = d;
      vecs[idx].expBus  = e;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;

      // Bench-driven entries expect to see the bench's own value unaltered, which only
      // holds if the DUT has released the bus.
      setVec(0,  "wr3",            1, 1, 0, 4'd3,  1, 32'h1234_5678, 32'h1234_5678);
      setVec(1,  "rd3",            1, 0, 1, 4'd3,  0, 32'h0,         32'h1234_5678);
      setVec(2,  "wr0",            1, 1, 0, 4'd0,  1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      setVec(3,  "wr15",           1, 1, 1, 4'd15, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      setVec(4,  "rd0",            1, 0, 1, 4'd0,  0, 32'h0,         32'hA5A5_A5A5);
      setVec(5,  "rd15",           1, 0, 1, 4'd15, 0, 32'h0,         32'hFFFF_FFFF);
      setVec(6,  "rd1",            1, 0, 1, 4'd1,  0, 32'h0,         32'h0000_0000);
      setVec(7,  "rd3again",       1, 0, 1, 4'd3,  0, 32'h0,         32'h1234_5678);
      setVec(8,  "oeLowReleased",  1, 0, 0, 4'd0,  1, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
      setVec(9,  "wrPriority5",    1, 1, 1, 4'd5,  1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      setVec(10, "csLowReleased",  0, 0, 1, 4'd0,  1, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
      setVec(11, "csLowWr7",       0, 1, 0, 4'd7,  1, 32'h1111_1111, 32'h1111_1111);
      setVec(12, "rd5",            1, 0, 1, 4'd5,  0, 32'h0,         32'hDEAD_BEEF);
      setVec(13, "rd7",            1, 0, 1, 4'd7,  0, 32'h0,         32'h0000_0000);
      setVec(14, "overwrite3",     1, 1, 0, 4'd3,  1, 32'h0000_CAFE, 32'h0000_CAFE);
      setVec(15, "rdAfterWr3",     1, 0, 1, 4'd3,  0, 32'h0,         32'h0000_CAFE);
      setVec(16, "csLowHold",      0, 1, 1, 4'd3,  1, 32'h0000_3501, 32'h0000_3501);

      rst     = 1'b1;
      cs      = 1'b1;
      we      = 1'b0;
      oe      = 1'b1;
      addr    = 4'd0;
      tbDrive = 1'b0;
      tbData  = 32'h0;
      #2;
      checkOutput("resetBus", 32'h0);
      @(posedge clk);
      #1;
      checkOutput("resetBusAfterEdge", 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput(vecs[i].name, vecs[i].expBus);
      end

      // Asynchronous reset between edges: read register (holding 0xCAFE) clears immediately.
      @(negedge clk);
      cs = 1'b1; we = 1'b0; oe = 1'b1; addr = 4'd3; tbDrive = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("preResetRd3", 32'h0000_CAFE);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncResetBus", 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rd3AfterReset", 32'h0);
      @(negedge clk);
      addr = 4'd15;
      @(posedge clk);
      #1;
      checkOutput("rd15AfterReset", 32'h0);

      // A write presented while rst is high is ignored.
      @(negedge clk);
      cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 4'd2;
      tbDrive = 1'b1; tbData = 32'h7777_7777;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("wrDuringReset", 32'h7777_7777);
      @(negedge clk);
      rst = 1'b0; we = 1'b0; oe = 1'b1; tbDrive = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rd2AfterResetWr", 32'h0);

      // First edge after reset release performs a normal write.
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      we = 1'b1; oe = 1'b0; tbDrive = 1'b1; tbData = 32'h1357_9BDF;
      @(posedge clk);
      #1;
      @(negedge clk);
      we = 1'b0; oe = 1'b1; tbDrive = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("resumeWr2", 32'h1357_9BDF);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/single_port_sync_ram.md
SINGLE_PORT_SYNC_RAM -- requirements
Module: single_port_sync_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address bus width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of storage words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all sequential logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port addr  input  ADDR_WIDTH  word address for read or write.
REQ-007 SHALL have port data  inout  DATA_WIDTH  bidirectional data bus; write data in, read data out.
REQ-008 SHALL have port cs  input  1  chip select, active-high; when low the block ignores we/oe and releases the bus.
REQ-009 SHALL have port we  input  1  write enable, active-high.
REQ-010 SHALL have port oe  input  1  output enable, active-high; gates the read data driver.

Function
REQ-011 SHALL hold DEPTH words of DATA_WIDTH bits in internal storage.
REQ-012 SHALL write data into mem[addr] on the rising clk edge when cs=1 and we=1; the new value is readable from the next edge.
REQ-013 SHALL capture mem[addr] into an internal read register on the rising clk edge when cs=1 and we=0, independent of oe.
REQ-014 SHALL drive data with the read register when cs=1, oe=1 and we=0 (combinational enable); read latency is one clock from address to valid data.
REQ-015 SHALL leave data at high impedance (all bits Z) whenever cs=0, oe=0 or we=1.
REQ-016 SHALL give write priority: with cs=1, we=1, oe=1 the write occurs, the read register holds its value, and the bus stays Z.
REQ-017 SHALL hold the read register unchanged on any edge where cs=0 or we=1.
REQ-018 SHALL ignore writes to addr >= DEPTH (no storage change) and load 0 into the read register on reads of addr >= DEPTH.
REQ-019 SHALL perform at most one access per cycle, with no read-during-write bypass to other addresses.
REQ-020 SHALL make a read of an address written on the previous edge return the newly written value.

Reset
REQ-021 SHALL, while rst=1, immediately and asynchronously clear every storage word and the read register to 0, regardless of clk.
REQ-022 SHALL ignore write and read captures on any edge where rst=1, including a reset asserted mid-access.
REQ-023 SHALL keep the bus Z/driven strictly per REQ-014/REQ-015 during reset; with cs=1, oe=1, we=0 it drives 0.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-025 SHALL pass: rst pulse, then cs=1, we=1, addr=3, data=0x12345678 for one edge; then we=0, oe=1, addr=3 -> after the next edge data reads 0x12345678.
REQ-026 SHALL pass: cs=1, oe=0 or cs=0 with any addr -> data is all-Z; the bench's own driver value is seen unaltered.
REQ-027 SHALL pass: write 0xA5A5A5A5 to addr 0 and 0xFFFFFFFF to addr 15, then read both -> 0xA5A5A5A5 and 0xFFFFFFFF, other addresses 0.
REQ-028 SHALL pass: after writing addr 3, assert rst asynchronously between edges, then read addr 3 -> 0x00000000.
REQ-029 SHALL pass: cs=1, we=1, oe=1, addr=5, data=0xDEADBEEF -> bus not driven by DUT that cycle; subsequent read of addr 5 returns 0xDEADBEEF.
REQ-030 SHALL pass: cs=0 with we=1, addr=7, data=0x11111111 -> subsequent read of addr 7 returns 0x00000000.
